// File: rtl/updown_counter_arbiter_pkg.sv
// Shared definitions for the up/down counter arbiter.
// Contents:
//   state_t  - arbiter FSM state encoding (IDLE, ISSUE, SETTLE)
//   DIR_INC  - req_dir value requesting +1
//   DIR_DEC  - req_dir value requesting -1
//   clog2()  - index width for a requester count (minimum 1 bit)
package counter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w = 1;
        while ((32'd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/updown_counter_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req     - request vector, one bit per requester
//   rr_ptr  - index with highest priority this round (must be < NUM_REQ)
//   any_req - at least one request bit set
//   winner  - first set request index searching upward from rr_ptr, wrapping
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any_req,
    output logic [IDX_W-1:0]   winner
);

    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] idx_n;
        any_req = |req;
        winner  = '0;
        idx     = 0;
        idx_n   = '0;
        // Walk from farthest to nearest offset so the nearest set bit wins.
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            idx = 32'(rr_ptr) + i - 1;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_n = IDX_W'(idx);
            if (req[idx_n]) begin
                winner = idx_n;
            end
        end
    end

endmodule

// File: rtl/updown_counter_arbiter.sv
// Round-robin arbiter sharing one up/down counter among NUM_REQ requesters.
// One request is executed per three cycles (IDLE -> ISSUE -> SETTLE) so the
// counter's registered count has settled before the next decision.
// Ports:
//   clk, reset          - clock (rising edge), synchronous active-high reset
//   req_valid, req_dir  - per-requester request and direction (1 = +1, 0 = -1)
//   count               - current value of the shared counter
//   increment/decrement - one-cycle strobes to the counter
//   gnt / rej           - one-hot one-cycle pulse: executed / refused
//   busy                - high in ISSUE and SETTLE
// Build option: define COUNTER_SAT_EN to refuse increments at all-ones and
// decrements at zero (rej pulse, no strobe) instead of letting the count wrap.
module updown_counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_dir,
    input  logic [WIDTH-1:0]   count,
    output logic               increment,
    output logic               decrement,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rej,
    output logic               busy
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic [IDX_W-1:0]   pick;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_dir;
    logic               sat_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .winner  (pick)
    );

    always_comb begin
        pick_onehot = NUM_REQ'(1) << pick;
        pick_dir    = req_dir[pick];
    end

`ifdef COUNTER_SAT_EN
    assign sat_hit = (pick_dir == DIR_INC) ? (count == '1) : (count == '0);
`else
    logic unused_count;
    assign unused_count = ^count;
    assign sat_hit      = 1'b0;
`endif

    // Outputs are registered, so the ISSUE-cycle strobe/gnt/rej values are
    // loaded on the IDLE->ISSUE edge; the strobe registers hold the latched
    // direction. count is stable then because the previous op has settled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            increment <= 1'b0;
            decrement <= 1'b0;
            gnt       <= '0;
            rej       <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            win_idx   <= '0;
        end else begin
            increment <= 1'b0;
            decrement <= 1'b0;
            gnt       <= '0;
            rej       <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_idx <= pick;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                        if (sat_hit) begin
                            rej <= pick_onehot;
                        end else begin
                            gnt       <= pick_onehot;
                            increment <= (pick_dir == DIR_INC);
                            decrement <= (pick_dir == DIR_DEC);
                        end
                    end
                end
                ISSUE: begin
                    rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_counter_arbiter.sv
// Self-checking bench for updown_counter_arbiter with a shared 4-bit counter.
// Build option: COUNTER_SAT_EN selects the refusal expectations.
module tb_updown_counter_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_dir;
    logic [3:0] count;
    logic       increment;
    logic       decrement;
    logic [3:0] gnt;
    logic [3:0] rej;
    logic       busy;
    logic       load;
    logic [3:0] load_val;

    always #5 clk = ~clk;

    // Shared counter; load is a bench-only preset used while the arbiter idles.
    always_ff @(posedge clk) begin
        if (reset)          count <= '0;
        else if (load)      count <= load_val;
        else if (increment) count <= count + 1'b1;
        else if (decrement) count <= count - 1'b1;
    end

    updown_counter_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_dir   (req_dir),
        .count     (count),
        .increment (increment),
        .decrement (decrement),
        .gnt       (gnt),
        .rej       (rej),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] rej;
        logic       inc;
        logic       dec;
        logic       chk_cnt;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         gnt_cyc[$];
    int         rem[4];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic       pend     = 1'b0;
    logic [3:0] pend_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [3:0] r, input logic i,
                        input logic d, input logic cc, input logic [3:0] c);
        exp_t e;
        e.gnt = g; e.rej = r; e.inc = i; e.dec = d; e.chk_cnt = cc; e.cnt = c;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and score whatever the DUT shows there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (reset) begin
            pend = 1'b0;
            return;
        end
        chk("inc_dec_exclusive", 32'(increment & decrement), 0);
        chk("gnt_rej_onehot0", 32'($onehot0(gnt | rej)), 1);
        if ((gnt | rej) != 4'b0) begin
            gnt_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_grant", 32'(gnt | rej), 0);
            end else begin
                e = sb.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("rej", 32'(rej), 32'(e.rej));
                chk("increment", 32'(increment), 32'(e.inc));
                chk("decrement", 32'(decrement), 32'(e.dec));
                chk("busy_issue", 32'(busy), 1);
                pend     = e.chk_cnt;
                pend_cnt = e.cnt;
            end
        end else if (pend) begin
            chk("count_after_op", 32'(count), 32'(pend_cnt));
            chk("busy_settle", 32'(busy), 1);
            chk("strobes_off_settle", 32'({increment, decrement}), 0);
            pend = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        load      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        gnt_cyc.delete();
    endtask

    task automatic load_count(input logic [3:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic set_rem(input int r0, input int r1, input int r2, input int r3);
        rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
    endtask

    // Requesters hold req_valid until their remaining op count is used up.
    task automatic run(input int budget);
        int n = 0;
        logic [3:0] gr;
        for (int k = 0; k < 4; k++) req_valid[k] = (rem[k] > 0);
        while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && n < budget) begin
            tick();
            n++;
            gr = gnt | rej;
            for (int k = 0; k < 4; k++) begin
                if (gr[k] && rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) req_valid[k] = 1'b0;
                end
            end
        end
        chk("run_within_budget", 32'(n < budget), 1);
        repeat (4) tick();
        chk("scoreboard_drained", 32'(sb.size()), 0);
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        int c0;
        reset     = 1'b1;
        req_valid = '0;
        req_dir   = '0;
        load      = 1'b0;
        load_val  = '0;

        // 1: single increment, latency and busy
        do_reset();
        chk("reset_outputs", 32'({increment, decrement, gnt, rej, busy}), 0);
        chk("reset_count", 32'(count), 0);
        req_dir = 4'b0001;
        set_rem(1, 0, 0, 0);
        push(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd1);
        c0 = cyc;
        run(20);
        chk("t1_grant_latency", 32'(gnt_cyc[0] - c0), 1);
        chk("t1_count", 32'(count), 1);

        // 2: four requesters, round-robin order 0,1,2,3,0 spaced 3 cycles
        do_reset();
        req_dir = 4'b1111;
        set_rem(2, 1, 1, 1);
        push(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd1);
        push(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd2);
        push(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd3);
        push(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd4);
        push(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd5);
        run(60);
        chk("t2_grant_count", 32'(gnt_cyc.size()), 5);
        for (int i = 1; i < gnt_cyc.size(); i++) begin
            chk("t2_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 3);
        end
        chk("t2_count", 32'(count), 5);

        // 3: req0 inc and req1 dec together, net zero
        do_reset();
        load_count(4'd7);
        req_dir = 4'b0001;
        set_rem(1, 1, 0, 0);
        push(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd8);
        push(4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd7);
        run(40);
        chk("t3_count", 32'(count), 7);

        // 4: increment at all-ones
        do_reset();
        load_count(4'd15);
        req_dir = 4'b0100;
        set_rem(0, 0, 1, 0);
`ifdef COUNTER_SAT_EN
        push(4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1, 4'd15);
        run(20);
        chk("t4_count", 32'(count), 15);
`else
        push(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd0);
        run(20);
        chk("t4_count", 32'(count), 0);
`endif

        // 5: decrement at zero
        do_reset();
        req_dir = 4'b0000;
        set_rem(0, 0, 0, 1);
`ifdef COUNTER_SAT_EN
        push(4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1, 4'd0);
        run(20);
        chk("t5_count", 32'(count), 0);
`else
        push(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd15);
        run(20);
        chk("t5_count", 32'(count), 15);
`endif

        // 6: reset during ISSUE; rr_ptr must restart at 0 (req0 before req1)
        do_reset();
        req_dir   = 4'b0011;
        req_valid = 4'b0010;
        push(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0);
        c0 = 0;
        while (gnt == 4'b0 && c0 < 20) begin
            tick();
            c0++;
        end
        chk("t6_reach_issue", 32'(gnt), 32'(4'b0010));
        reset = 1'b1;
        tick();
        chk("t6_reset_outputs", 32'({increment, decrement, gnt, rej, busy}), 0);
        chk("t6_reset_count", 32'(count), 0);
        reset = 1'b0;
        set_rem(1, 1, 0, 0);
        push(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd1);
        push(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd2);
        run(40);
        repeat (6) tick();
        chk("t6_count", 32'(count), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
